// File: rtl/main_function_arbiter.sv
// main_function_arbiter
// Round-robin arbiter and sequencer sharing a single multi-cycle main_function
// unit among N requesters. The winner's operands are latched at grant, the unit
// is started with a one-cycle enable, and the result (or a watchdog timeout
// error) is returned to the winner with a one-cycle done strobe.
module main_function_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [23:0]      rsp_result,
  output logic             rsp_error,
  output logic             busy,
  output logic             unit_enable,
  output logic [7:0]       unit_a,
  output logic [7:0]       unit_b,
  input  logic             unit_finish,
  input  logic [23:0]      unit_result
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   last_r, last_s;
  logic [IW-1:0]   win_r, win_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   pick_s;
  logic [N-1:0]    gnt_s;
  logic [N-1:0]    done_s;
  logic [23:0]     rsp_result_s;
  logic            rsp_error_s;
  logic            busy_s;
  logic            unit_enable_s;
  logic [7:0]      unit_a_s;
  logic [7:0]      unit_b_s;

  // Round-robin search: first requester found starting one past the last served.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      cand = IW'(idx);
      if (!found && r[cand]) begin
        found = 1'b1;
        pick  = cand;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Winner candidate for the current request vector.
  always_comb begin
    pick_s = rr_pick(req, last_r);
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s       = state_r;
    last_s        = last_r;
    win_s         = win_r;
    cnt_s         = cnt_r;
    gnt_s         = gnt;
    done_s        = ZERO_N;
    rsp_result_s  = rsp_result;
    rsp_error_s   = rsp_error;
    unit_enable_s = 1'b0;
    unit_a_s      = unit_a;
    unit_b_s      = unit_b;
    case (state_r)
      IDLE: begin
        if (req != ZERO_N) begin
          state_s       = ISSUE;
          win_s         = pick_s;
          gnt_s         = ONE_N << pick_s;
          unit_enable_s = 1'b1;
          unit_a_s      = req_a[{pick_s, 3'b000} +: 8];
          unit_b_s      = req_b[{pick_s, 3'b000} +: 8];
        end else begin
          gnt_s = ZERO_N;
        end
      end
      ISSUE: begin
        state_s = WAIT;
        cnt_s   = CNT_ZERO;
      end
      WAIT: begin
        if (unit_finish) begin
          state_s      = RESP;
          rsp_result_s = unit_result;
          rsp_error_s  = 1'b0;
          done_s       = gnt;
        end else if (cnt_r == CNT_MAX) begin
          // Watchdog expired: report an error instead of a result.
          state_s      = RESP;
          rsp_result_s = 24'h000000;
          rsp_error_s  = 1'b1;
          done_s       = gnt;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
        last_s  = win_r;
        gnt_s   = ZERO_N;
      end
      default: begin
        state_s = IDLE;
        last_s  = LAST_RST;
        gnt_s   = ZERO_N;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      last_r      <= LAST_RST;
      win_r       <= {IW{1'b0}};
      cnt_r       <= CNT_ZERO;
      gnt         <= ZERO_N;
      done        <= ZERO_N;
      rsp_result  <= 24'h000000;
      rsp_error   <= 1'b0;
      busy        <= 1'b0;
      unit_enable <= 1'b0;
      unit_a      <= 8'h00;
      unit_b      <= 8'h00;
    end else begin
      state_r     <= state_s;
      last_r      <= last_s;
      win_r       <= win_s;
      cnt_r       <= cnt_s;
      gnt         <= gnt_s;
      done        <= done_s;
      rsp_result  <= rsp_result_s;
      rsp_error   <= rsp_error_s;
      busy        <= busy_s;
      unit_enable <= unit_enable_s;
      unit_a      <= unit_a_s;
      unit_b      <= unit_b_s;
    end
  end

endmodule

// File: tb/tb_main_function_arbiter.sv
// Testbench for main_function_arbiter: stub main_function unit, directed
// scenarios plus randomized requests checked against a round-robin model.
module tb_main_function_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [23:0]   rsp_result;
  logic          rsp_error;
  logic          busy;
  logic          unit_enable;
  logic [7:0]    unit_a;
  logic [7:0]    unit_b;
  logic          unit_finish;
  logic [23:0]   unit_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0;
  int stub_lat = 1;
  int s_cnt;
  logic [7:0] s_a, s_b;

  int model_last;
  int last_w;
  int last_done_cyc;
  logic [23:0] last_rsp;
  logic        last_err;

  main_function_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .unit_enable(unit_enable), .unit_a(unit_a), .unit_b(unit_b),
    .unit_finish(unit_finish), .unit_result(unit_result)
  );

  always #5 clock = ~clock;

  // Cycle counter and enable-pulse counter.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (unit_enable) en_count <= en_count + 1;
  end

  // Stub unit: result {a,b,5A} L cycles after enable; stub_lat==0 never finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_cnt <= 0; s_a <= 8'h00; s_b <= 8'h00;
      unit_finish <= 1'b0; unit_result <= 24'h000000;
    end else if (unit_enable) begin
      s_cnt <= stub_lat; s_a <= unit_a; s_b <= unit_b; unit_finish <= 1'b0;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        unit_finish <= 1'b1;
        unit_result <= {s_a, s_b, 8'h5A};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"}, 32'(unit_enable), 32'd0);
    chk({tag, "_ua"}, 32'(unit_a), 32'd0);
    chk({tag, "_ub"}, 32'(unit_b), 32'd0);
    chk({tag, "_res"}, 32'(rsp_result), 32'd0);
    chk({tag, "_err"}, 32'(rsp_error), 32'd0);
  endtask

  // Reference round-robin: first requester at (last+k) mod N, k = 1..N.
  function automatic int ref_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One complete operation, starting in an IDLE cycle with req already set.
  task automatic run_op(input int lat, input bit chg, input bit drop);
    int w, g, n, en0, exp_lat;
    logic [7:0] a, b;
    logic [23:0] exp_res;
    w = ref_pick(model_last, req);
    if (w < 0) w = 0;
    a = req_a[8*w +: 8];
    b = req_b[8*w +: 8];
    stub_lat = lat;
    exp_lat  = (lat == 0) ? TO + 2 : lat + 2;
    exp_res  = (lat == 0) ? 24'h000000 : {a, b, 8'h5A};
    en0 = en_count;
    g   = cyc + 1;
    tick();
    chk("issue_gnt", 32'(gnt), 32'(4'b0001 << w));
    chk("issue_en", 32'(unit_enable), 32'd1);
    chk("issue_a", 32'(unit_a), 32'(a));
    chk("issue_b", 32'(unit_b), 32'(b));
    chk("issue_busy", 32'(busy), 32'd1);
    if (chg) req_a[8*w +: 8] = 8'd99;
    if (drop) req[w] = 1'b0;
    tick();
    chk("wait_en", 32'(unit_enable), 32'd0);
    chk("wait_a", 32'(unit_a), 32'(a));
    chk("wait_gnt", 32'(gnt), 32'(4'b0001 << w));
    n = 0;
    while (done === 4'b0000 && n < TO + 8) begin
      tick();
      n++;
    end
    last_done_cyc = cyc;
    last_rsp = rsp_result;
    last_err = rsp_error;
    chk("done_vec", 32'(done), 32'(4'b0001 << w));
    chk("done_lat", 32'(cyc - g), 32'(exp_lat));
    chk("done_res", 32'(rsp_result), 32'(exp_res));
    chk("done_err", 32'(rsp_error), (lat == 0) ? 32'd1 : 32'd0);
    chk("done_a", 32'(unit_a), 32'(a));
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_gnt", 32'(gnt), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("en_pulses", 32'(en_count - en0), 32'd1);
    model_last = w;
    last_w = w;
  endtask

  initial begin
    int prev;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0;
    model_last = N - 1;
    #1;
    chk_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_zero("idle");

    // All four requesting continuously, L=2: order 0,1,2,3,0, period 6.
    req = 4'b1111; req_a = 32'h44332211; req_b = 32'h88776655;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(2, 1'b0, 1'b0);
      chk("b2b_order", 32'(last_w), 32'(i % 4));
      if (i > 0) chk("b2b_period", 32'(last_done_cyc - prev), 32'd6);
      prev = last_done_cyc;
    end

    // Single request from requester 1.
    req = 4'b0010; req_a = 32'h00007B00; req_b = 32'h00002100;
    run_op(5, 1'b0, 1'b0);
    chk("single_res", 32'(last_rsp), 32'h007B215A);

    // Timeout: unit never finishes.
    req = 4'b0100; req_a = 32'h00FF0000; req_b = 32'h00FF0000;
    run_op(0, 1'b0, 1'b0);
    chk("to_err", 32'(last_err), 32'd1);

    // Operand change after grant has no effect.
    req = 4'b1000; req_a = 32'h0A000000; req_b = 32'h07000000;
    run_op(3, 1'b1, 1'b0);
    chk("stab_res_hi", 32'(last_rsp[23:16]), 32'd10);

    // Randomized requests against the round-robin model.
    for (int i = 0; i < 24; i++) begin
      req   = 4'($urandom_range(1, 15));
      req_a = $urandom;
      req_b = $urandom;
      run_op(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT.
    req = 4'b0001; req_a = 32'h000000C3; req_b = 32'h0000003C;
    stub_lat = 10;
    tick(); tick(); tick(); tick();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero("async_rst");
    req = '0;
    tick(); tick();
    chk("rst_hold_done", 32'(done), 32'd0);
    reset = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_no_done", 32'(done), 32'd0);
    end
    req = 4'b0001;
    run_op(2, 1'b0, 1'b0);
    chk("rst_first", 32'(last_w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_function_arbiter.md
# main_function_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `main_function` unit among N requesters. It latches the winning requester's operands and pulses the unit's `enable` for one cycle. It then waits for `finish`, or for a watchdog timeout, and returns the 24-bit result to the winner with a one-cycle done strobe. It sits between the requester-side logic and the single `main_function` instance, which shares the same clock and reset.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 1024: maximum WAIT cycles before an error response (≥ 2).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; also drives the unit's reset.
- `req` in N: level request per requester.
- `req_a` in 8N: operand a, requester i at bits [8i+7:8i].
- `req_b` in 8N: operand b, same packing.
- `gnt` out N: one-hot index of the requester being served; 0 when idle.
- `done` out N: one-cycle one-hot completion strobe.
- `rsp_result` out 24: result, valid while `done` != 0.
- `rsp_error` out 1: timeout flag, valid while `done` != 0.
- `busy` out 1: high in any state other than IDLE.
- `unit_enable` out 1: start pulse to `main_function`.
- `unit_a` out 8: operand to the unit.
- `unit_b` out 8: operand to the unit.
- `unit_finish` in 1: unit completion flag.
- `unit_result` in 24: unit result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE:
  - On each edge with `req` != 0, choose the winner by round-robin.
  - The search starts at `last`+1 mod N; `last` is the most recently served index, reset value N-1, so index 0 wins first.
  - Latch the winner index, `req_a` slice and `req_b` slice, then go to ISSUE.
- ISSUE (1 cycle): `unit_enable`=1, with `unit_a`/`unit_b` carrying the latched operands. Next state WAIT; clear the watchdog counter.
- WAIT:
  - `unit_enable`=0; operands stay stable.
  - If `unit_finish`=1 at an edge: capture `unit_result` into `rsp_result`, set `rsp_error`=0, go to RESP.
  - Otherwise increment the counter (width clog2(TIMEOUT+1)).
  - When the counter reaches TIMEOUT with no finish: `rsp_result`=0, `rsp_error`=1, go to RESP.
- RESP (1 cycle): `done`[winner]=1; update `last` to the winner; next state IDLE.
- `gnt`[winner] is high from ISSUE through RESP inclusive.
- Operands are latched at grant. Changes on `req_a`/`req_b` after the grant edge have no effect on the current operation.
- A requester dropping `req` while granted does not abort the operation; its `done` still pulses.
- `req` still high at the edge ending the first IDLE cycle after `done` counts as a new request, subject to round-robin. Lower it during or immediately after the `done` cycle.
- `unit_finish` is ignored in IDLE, ISSUE and RESP. A stale finish from a previous operation cannot complete a new one.
- Reset, at any time including mid-WAIT:
  - State IDLE, `last`=N-1.
  - `gnt`=0, `done`=0, `busy`=0, `unit_enable`=0.
  - `unit_a`=0, `unit_b`=0, `rsp_result`=0, `rsp_error`=0.
  - No `done` is issued for the aborted request.

## Timing
- Grant: `req` high at edge t0 while in IDLE gives ISSUE during cycle t0+1, with `unit_enable` high for exactly one cycle.
- Unit finish: if the unit raises `finish` at edge t0+1+L, L ≥ 1, then RESP and `done` are high during cycle t0+2+L.
- Occupancy per operation: L+3 cycles, counted from the IDLE-sampling edge through RESP.
- Back-to-back service: with continuous requests, the next ISSUE starts 2 cycles after RESP (one IDLE cycle).
- Timeout: `done` with `rsp_error`=1 occurs at cycle t0+TIMEOUT+2.
- Fairness: no requester waits more than N-1 services.

## Test plan
- Bench stub unit: returns `result` = {a, b, 8'h5A} L cycles after `enable`; `finish` drops on `enable`.
- Single request: requester 1, a=123, b=33, L=5, others idle.
  - `unit_enable` pulses once with a=8'd123, b=8'd33.
  - `done`=4'b0010 with `rsp_result`=24'h7B215A and `rsp_error`=0, 8 cycles after `req`.
- All four requesting continuously, L=2: served in order 0,1,2,3,0.
  - `done` one-hot each time; 6 cycles between consecutive `done` pulses.
- Timeout: stub never asserts `finish`, TIMEOUT=16, requester 2 with a=b=255.
  - `done`=4'b0100, `rsp_error`=1, `rsp_result`=0, exactly 18 cycles after the grant edge.
- Operand stability: change `req_a` from 8'd10 to 8'd99 one cycle after the grant; `unit_a` stays 10 throughout and `rsp_result`[23:16]=8'd10.
- Reset mid-WAIT: assert `reset` during WAIT.
  - All outputs go to 0 asynchronously; no `done` pulse.
  - After release, requester 0 re-requesting is granted first and served normally.
